// File: rtl/data_memory_responder_pkg.sv
// data_memory_responder_pkg: size codes, FSM states and lane/extension helpers for the data-memory responder
package data_memory_responder_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [3:0] ECAUSE_LOAD_MISALIGN = 4'd4;
    localparam logic [3:0] ECAUSE_STORE_MISALIGN = 4'd6;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [3:0] lane_be(logic [1:0] a, logic [1:0] sz);
        return sz == SIZE_BYTE ? 4'b0001 << a :
               sz == SIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) :
               sz == SIZE_WORD ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic [31:0] store_wdata(logic [31:0] d, logic [1:0] sz);
        return sz == SIZE_BYTE ? {4{d[7:0]}} : sz == SIZE_HALF ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic [31:0] load_extract(logic [31:0] w, logic [1:0] a, logic [1:0] sz, logic sg);
        logic [7:0] b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        return sz == SIZE_BYTE ? {{24{sg & b[7]}}, b} :
               sz == SIZE_HALF ? {{16{sg & h[15]}}, h} :
               sz == SIZE_WORD ? w : 32'd0;
    endfunction
endpackage

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: memory-stage to data-memory request/response bus
interface data_memory_responder_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_store_data;
    logic        mem_load;
    logic        mem_store;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] mem_load_data;
    logic        mem_ready;

    modport master (output mem_addr, mem_store_data, mem_load, mem_store, mem_size, mem_signed,
                    input mem_load_data, mem_ready);
    modport slave (input mem_addr, mem_store_data, mem_load, mem_store, mem_size, mem_signed,
                   output mem_load_data, mem_ready);
endinterface

// File: rtl/data_ram_bytewise.sv
// data_ram_bytewise: byte-enabled word RAM with registered read, block-RAM friendly
module data_ram_bytewise #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: latency-configurable responder owning the data RAM, with store lane steering and load extension
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input logic clk,
    input logic rst_n,
    data_memory_responder_if.slave bus
);
    localparam int AW = DEPTH_LOG2 + 2;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [AW-1:0] addr_q;
    logic [31:0] data_q, rdata, load_data_q;
    logic [1:0]  size_q;
    logic        sgn_q, store_q, req, acc, ready;
    logic [3:0]  we;
    logic [DEPTH_LOG2-1:0] raddr;

    assign req = bus.mem_load || bus.mem_store;
    assign acc = state == BUSY && req && cnt == 4'd0;
    assign we = acc && store_q ? lane_be(addr_q[1:0], size_q) : 4'b0000;
    // Read the incoming address while idle so the word is ready by the access edge even at LATENCY=1
    assign raddr = state == IDLE ? bus.mem_addr[AW-1:2] : addr_q[AW-1:2];
    assign bus.mem_ready = ready;
    assign bus.mem_load_data = load_data_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        ready = 1'b0;
        case (state)
            IDLE: begin
                ready = !req;
                state_nx = req ? BUSY : IDLE;
            end
            BUSY: state_nx = !req ? IDLE : (cnt == 4'd0 ? DONE : BUSY);
            DONE: begin
                ready = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= 4'd0;
            addr_q <= '0;
            data_q <= 32'd0;
            size_q <= 2'b00;
            sgn_q <= 1'b0;
            store_q <= 1'b0;
            load_data_q <= 32'd0;
        end else begin
            if (state == IDLE && req) begin
                addr_q <= bus.mem_addr[AW-1:0];
                data_q <= bus.mem_store_data;
                size_q <= bus.mem_size;
                sgn_q <= bus.mem_signed;
                store_q <= bus.mem_store;
                cnt <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // rdata is the pre-write word, so a combined load+store returns the old contents
            if (acc) load_data_q <= load_extract(rdata, addr_q[1:0], size_q, sgn_q);
        end

    data_ram_bytewise #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (addr_q[AW-1:2]),
        .wdata (store_wdata(data_q, size_q)),
        .raddr (raddr),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed vectors with hand-computed results for data_memory_responder
module tb_data_memory_responder;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vecs = 0;
    int errs = 0;
    logic [31:0] rd;

    data_memory_responder_if bus();

    data_memory_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int n, output logic [31:0] data);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.mem_ready) break;
        end
        if (!bus.mem_ready) check("timeout", 32'd0, 32'd1);
        data = bus.mem_load_data;
    endtask

    task automatic txn(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic sg, input bit keep, output logic [31:0] data);
        int n;
        @(posedge clk);
        @(negedge clk);
        bus.mem_load = ld;
        bus.mem_store = st;
        bus.mem_addr = a;
        bus.mem_store_data = d;
        bus.mem_size = sz;
        bus.mem_signed = sg;
        #1 check("stall", {31'd0, bus.mem_ready}, 32'd0);
        wait_done(n, data);
        check("latency", 32'(n), 32'(LAT + 1));
        if (!keep) begin
            bus.mem_load = 1'b0;
            bus.mem_store = 1'b0;
        end
    endtask

    initial begin
        int n;
        bus.mem_load = 1'b0;
        bus.mem_store = 1'b0;
        bus.mem_addr = 32'd0;
        bus.mem_store_data = 32'd0;
        bus.mem_size = 2'b10;
        bus.mem_signed = 1'b0;
        #12;
        check("rst_ready", {31'd0, bus.mem_ready}, 32'd1);
        check("rst_data", bus.mem_load_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1 check("idle_ready", {31'd0, bus.mem_ready}, 32'd1);

        txn(0, 1, 32'h100, 32'hDEADBEEF, 2'b10, 0, 0, rd);
        txn(1, 0, 32'h100, 32'h0, 2'b10, 0, 0, rd);
        check("word_rt", rd, 32'hDEADBEEF);

        txn(0, 1, 32'h100, 32'h11223344, 2'b10, 0, 0, rd);
        txn(0, 1, 32'h103, 32'h00000080, 2'b00, 0, 0, rd);
        txn(1, 0, 32'h100, 32'h0, 2'b10, 0, 0, rd);
        check("sb_word", rd, 32'h80223344);
        txn(1, 0, 32'h103, 32'h0, 2'b00, 1, 0, rd);
        check("lb_103", rd, 32'hFFFFFF80);
        txn(1, 0, 32'h103, 32'h0, 2'b00, 0, 0, rd);
        check("lbu_103", rd, 32'h00000080);
        txn(1, 0, 32'h102, 32'h0, 2'b01, 1, 0, rd);
        check("lh_102", rd, 32'hFFFF8022);
        txn(1, 0, 32'h100, 32'h0, 2'b01, 0, 0, rd);
        check("lhu_100", rd, 32'h00003344);
        txn(1, 0, 32'h101, 32'h0, 2'b00, 1, 0, rd);
        check("lb_101", rd, 32'h00000033);
        txn(1, 0, 32'h100, 32'h0, 2'b11, 1, 0, rd);
        check("l_rsvd", rd, 32'h00000000);

        txn(1, 1, 32'h100, 32'h55667788, 2'b10, 0, 0, rd);
        check("ldst_old", rd, 32'h80223344);
        txn(1, 0, 32'h100, 32'h0, 2'b10, 0, 0, rd);
        check("ldst_new", rd, 32'h55667788);

        txn(0, 1, 32'h104, 32'h13579BDF, 2'b10, 0, 0, rd);
        txn(0, 1, 32'h106, 32'h1234ABCD, 2'b01, 0, 0, rd);
        txn(1, 0, 32'h104, 32'h0, 2'b10, 0, 0, rd);
        check("sh_106", rd, 32'hABCD9BDF);
        txn(0, 1, 32'h105, 32'hFFFFFF77, 2'b00, 0, 0, rd);
        txn(0, 1, 32'h104, 32'h00000000, 2'b11, 0, 0, rd);
        txn(1, 0, 32'h104, 32'h0, 2'b10, 0, 0, rd);
        check("sb_105_rsvd", rd, 32'hABCD77DF);
        txn(1, 0, 32'h105, 32'h0, 2'b01, 0, 0, rd);
        check("lhu_105", rd, 32'h000077DF);

        txn(0, 1, 32'h200, 32'h12345678, 2'b10, 0, 0, rd);
        txn(1, 0, 32'h200, 32'h0, 2'b10, 0, 0, rd);
        @(posedge clk);
        @(negedge clk);
        bus.mem_store = 1'b1;
        bus.mem_addr = 32'h200;
        bus.mem_store_data = 32'hAAAAAAAA;
        bus.mem_size = 2'b10;
        @(posedge clk) #1 bus.mem_store = 1'b0;
        #1 check("abort_busy", {31'd0, bus.mem_ready}, 32'd0);
        @(posedge clk) #1 check("abort_idle", {31'd0, bus.mem_ready}, 32'd1);
        check("abort_data", bus.mem_load_data, 32'h12345678);
        txn(1, 0, 32'h200, 32'h0, 2'b10, 0, 0, rd);
        check("abort_word", rd, 32'h12345678);

        txn(0, 1, 32'h300, 32'h0BADF00D, 2'b10, 0, 0, rd);
        @(posedge clk);
        @(negedge clk);
        bus.mem_store = 1'b1;
        bus.mem_addr = 32'h300;
        bus.mem_store_data = 32'hCAFEBABE;
        bus.mem_size = 2'b10;
        @(posedge clk) #1 rst_n = 1'b0;
        #1 check("rst_busy_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("rst_busy_data", bus.mem_load_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(n, rd);
        check("rst_restart_lat", 32'(n), 32'(LAT + 1));
        check("rst_no_write", rd, 32'h0BADF00D);
        bus.mem_store = 1'b0;
        txn(1, 0, 32'h300, 32'h0, 2'b10, 0, 0, rd);
        check("rst_restart_word", rd, 32'hCAFEBABE);

        txn(1, 0, 32'h104, 32'h0, 2'b10, 0, 1, rd);
        check("b2b_0", rd, 32'hABCD77DF);
        for (int i = 0; i < 2; i++) begin
            wait_done(n, rd);
            check("b2b_lat", 32'(n), 32'(LAT + 2));
            check("b2b_data", rd, 32'hABCD77DF);
        end
        bus.mem_load = 1'b0;
        txn(1, 0, 32'h1104, 32'h0, 2'b10, 0, 0, rd);
        check("alias_1104", rd, 32'hABCD77DF);
        txn(1, 0, 32'h80001104, 32'h0, 2'b10, 0, 0, rd);
        check("alias_high", rd, 32'hABCD77DF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
